// File: rtl/nervous_pkg.sv
// Shared code constants, pattern tables and FSM state type for the nervous
// pattern generator and the detector model that consumes its stream.
package nervous_pkg;

  localparam logic [1:0] CODE_NORMAL = 2'b00;
  localparam logic [1:0] CODE_A      = 2'b01;
  localparam logic [1:0] CODE_B      = 2'b10;
  localparam logic [1:0] CODE_C      = 2'b11;

  // Bit 9 goes out first; shorter patterns are left-aligned and zero-padded.
  localparam logic [3:0][9:0] PATTERN = {
    10'b1010101010,   // CODE_C
    10'b1010101110,   // CODE_B
    10'b1010100000,   // CODE_A
    10'b1100000000    // CODE_NORMAL
  };

  localparam logic [3:0][3:0] PAT_LEN = {4'd10, 4'd10, 4'd7, 4'd4};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SEND  = 2'd1,
    GUARD = 2'd2
  } npg_state_e;

endpackage

// File: rtl/nervous_pattern_rom.sv
// Combinational lookup from abnormality code to its serial pattern and length.
module nervous_pattern_rom
  import nervous_pkg::*;
(
  input  logic [1:0] code_i,
  output logic [9:0] pattern_o,
  output logic [3:0] len_o
);

  assign pattern_o = PATTERN[code_i];
  assign len_o     = PAT_LEN[code_i];

endmodule

// File: rtl/nervous_pattern_generator.sv
// Serialises a 2-bit abnormality code into the detector's bit pattern,
// followed by a run of GUARD_BITS zeros so the detector returns to idle.
module nervous_pattern_generator
  import nervous_pkg::*;
#(
  parameter int GUARD_BITS = 3
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       req_valid,
  input  logic [1:0] req_code,
  output logic       req_ready,
  output logic       outputdata,
  output logic       busy,
  output logic       frame_done
);

  if (GUARD_BITS < 2 || GUARD_BITS > 15) begin : g_bad_guard
    $error("nervous_pattern_generator: GUARD_BITS must be in 2..15");
  end

  localparam logic [3:0] GLAST = 4'(GUARD_BITS - 1);

  npg_state_e state_q, state_d;
  logic [1:0] code_q, code_d;
  logic [3:0] bit_idx_q, bit_idx_d;
  logic [3:0] guard_cnt_q, guard_cnt_d;
  logic       out_q, out_d;

  logic [1:0] rom_code;
  logic [9:0] rom_pat;
  logic [3:0] rom_len;
  logic [3:0] nxt_idx;

  // In IDLE the ROM looks at the incoming request so bit 0 can be registered
  // on the accept edge; afterwards it follows the latched code.
  assign rom_code = (state_q == IDLE) ? req_code : code_q;

  nervous_pattern_rom u_rom (
    .code_i    (rom_code),
    .pattern_o (rom_pat),
    .len_o     (rom_len)
  );

  assign nxt_idx = bit_idx_q + 4'd1;

  always_comb begin
    state_d     = state_q;
    code_d      = code_q;
    bit_idx_d   = bit_idx_q;
    guard_cnt_d = guard_cnt_q;
    out_d       = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          state_d   = SEND;
          code_d    = req_code;
          bit_idx_d = 4'd0;
          out_d     = rom_pat[9];
        end
      end
      SEND: begin
        if (bit_idx_q == rom_len - 4'd1) begin
          state_d     = GUARD;
          bit_idx_d   = 4'd0;
          guard_cnt_d = 4'd0;
        end else begin
          bit_idx_d = nxt_idx;
          out_d     = rom_pat[4'd9 - nxt_idx];
        end
      end
      GUARD: begin
        if (guard_cnt_q == GLAST) begin
          state_d     = IDLE;
          guard_cnt_d = 4'd0;
        end else begin
          guard_cnt_d = guard_cnt_q + 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      code_q      <= CODE_NORMAL;
      bit_idx_q   <= 4'd0;
      guard_cnt_q <= 4'd0;
      out_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      code_q      <= code_d;
      bit_idx_q   <= bit_idx_d;
      guard_cnt_q <= guard_cnt_d;
      out_q       <= out_d;
    end
  end

  assign outputdata = out_q;
  assign req_ready  = (state_q == IDLE);
  assign busy       = (state_q != IDLE);
  assign frame_done = (state_q == GUARD) && (guard_cnt_q == GLAST);

endmodule
